mpu_stack_guard: RTL and testbench
==================================

// Module: mpu_stack_guard
// PURPOSE
// - Parametrised memory protection unit sitting beside the LSU. Checks every load/store address against
//   the running task's own stack frame and a CSR-programmed per-task region table.
// - Tracks nested interrupt entry points on a hardware stack: push on preemption, pop on return.
// - Raises a registered fault to n-clic and latches fault address and cause until software clears them.
// PARAMETERS
// - AddrWidth   16     address/sp width in bits, range 8..16
// - Maps        9      number of task region maps, indexed by id
// - Rows        4      regions per map
// - PrioLevels  8      interrupt priority levels; also the entry-point stack depth
// - CsrBase     'h400  CSR address of map0/row0; entry k,i sits at CsrBase + i + Rows*k
// - StackTop    'hFFFF entry point used when the entry-point stack is empty (base task)
// PORTS
// - clk             in   1                 clock
// - reset           in   1                 asynchronous, active-high reset
// - addr            in   AddrWidth         access address
// - sp              in   AddrWidth         current stack pointer
// - op              in   7                 opcode; only OP_LOAD and OP_STORE are checked
// - interrupt_prio  in   $clog2(PrioLevels) running priority
// - id              in   $clog2(Maps)      running task id
// - csr_enable, csr_addr, rs1_zimm, rs1_data, csr_op  in  -  standard CSR write path
// - vcsr_addr, vcsr_width, vcsr_offset                in  -  standard VCSR path
// - fault_clear     in   1                 clears the sticky fault record
// - mem_fault_out   out  1                 one-cycle fault pulse to n-clic
// - fault_valid     out  1                 sticky: a fault is recorded
// - fault_addr      out  AddrWidth         address of the first unhandled fault
// - fault_cause     out  2                 0 none, 1 load, 2 store, 3 ep-stack over/underflow
// BEHAVIOUR
// - Reset state: all outputs 0, ep stack empty (ep = StackTop), last_prio = 0, current_map = map 0.
//   Reset applies immediately, including mid-access; the pending check is dropped.
// - Region word (32b): [31:18] base>>2, [17:2] length, [1] write_en, [0] read_en.
//   - Region spans bot = {base,2'b00} up to top = bot + length, top exclusive.
//   - bot + length is computed at AddrWidth+1 bits; a carry saturates top to 2^AddrWidth.
//   - length 0 disables the row.
// - current_map is registered from the table on id. A new id takes effect for accesses 1 cycle later.
// - Entry-point stack:
//   - prio > last_prio (preempt): push sp. New ep = sp.
//   - prio < last_prio (return): pop once per cycle until the stored prio <= new prio. Each entry
//     stores {prio, sp}.
//   - Push when full, or pop when empty: cause 3. The stack is unchanged.
//   - An access in the same cycle as a prio change is checked against the old ep.
// - Access check, for OP_LOAD/OP_STORE only:
//   - own = (addr >= sp) && (addr < ep).
//   - grant = OR over rows of (bot <= addr < top) && (load ? read_en : write_en).
//   - Fault = !(own || grant).
// - Latency: access presented in cycle N -> mem_fault_out high for exactly cycle N+1. No stall, one
//   check per cycle, back-to-back supported.
// - Fault record:
//   - On a fault pulse with fault_valid = 0: latch addr and cause, set fault_valid.
//   - Later faults pulse mem_fault_out but do not overwrite the record.
//   - fault_clear clears the record. If a fault arrives in the same cycle, the new fault is recorded
//     (set wins).
// - The CSR write to a region takes effect on the next current_map reload, i.e. 2 cycles after the
//   write if id is constant.
// STRUCTURE
// - Shared package: op_t (OP_LOAD, OP_STORE), mpu_region_t packed struct, mpu_cause_t enum.
//   CsrAddrT, word, r, csr_op_t and vcsr_* come from the existing package.
// - Sub-module mpu_ep_stack: parametrised LIFO of {prio, sp} with push/pop/full/empty and an
//   error output.
// - Region CSRs: Maps*Rows csr instances, ext_write_enable tied to 0.
// TESTING
// - Reset, then prio 0, sp='h8000, load 'h8010 -> no fault. Load 'h7FF0 -> mem_fault_out at N+1,
//   fault_addr='h7FF0, cause 1.
// - Map id 2, row0 base 'h1000, len 'h100, r=1, w=0:
//   - load 'h10FC -> ok
//   - store 'h1010 -> cause 2
//   - load 'h1100 -> fault (top exclusive)
// - Prio 0->3 with sp='h9000, then 3->5 with sp='h8800:
//   - load 'h8900 at prio 5 -> fault (ep = 'h8800)
//   - after 5->3, load 'h8900 -> ok (ep = 'h9000)
// - Push PrioLevels+1 nested levels -> cause 3 and the stack is unchanged. Return to prio 0 -> the
//   stack ends empty with no further error.
// - Two faults back-to-back -> record keeps the first. fault_clear in the same cycle as a fault ->
//   the new fault is recorded.
// - Assert reset mid-stream with fault_valid=1 and the stack non-empty -> all outputs 0 at once and
//   ep = StackTop.

Source files
------------

// File: rtl/mpu_stack_guard_pkg.sv
// mpu_stack_guard_pkg: shared opcode, region, cause and CSR-op types for the stack guard MPU
package mpu_stack_guard_pkg;
  typedef enum logic [6:0] {
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011
  } op_t;
  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_LOAD,
    CAUSE_STORE,
    CAUSE_EP
  } mpu_cause_t;
  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;
  typedef struct packed {
    logic [13:0] base;
    logic [15:0] length;
    logic        write_en;
    logic        read_en;
  } mpu_region_t;
  function automatic logic [31:0] csr_apply(logic [2:0] op, logic [31:0] old, logic [31:0] src);
    return op[1:0] == 2'b01 ? src : op[1:0] == 2'b10 ? old | src : op[1:0] == 2'b11 ? old & ~src : old;
  endfunction
endpackage

// File: rtl/mpu_stack_guard_ep_stack.sv
// mpu_ep_stack: LIFO of {prio, sp} interrupt entry points; a refused push or pop flags err_o
module mpu_ep_stack #(
  parameter int Depth = 8,
  parameter int PW    = 3,
  parameter int AW    = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [PW-1:0] prio_i,
  input  logic [AW-1:0] sp_i,
  output logic [PW-1:0] top_prio_o,
  output logic [AW-1:0] top_sp_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          err_o
);
  localparam int CW = $clog2(Depth + 1);
  localparam int IW = Depth > 1 ? $clog2(Depth) : 1;
  typedef struct packed {
    logic [PW-1:0] prio;
    logic [AW-1:0] sp;
  } ep_entry_t;
  ep_entry_t     mem_q [Depth];
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] top_idx;
  assign full_o     = cnt_q == CW'(Depth);
  assign empty_o    = cnt_q == '0;
  assign err_o      = push_i && full_o || pop_i && empty_o;
  assign top_idx    = empty_o ? '0 : IW'(cnt_q - 1'b1);
  assign top_prio_o = mem_q[top_idx].prio;
  assign top_sp_o   = mem_q[top_idx].sp;
  // occupancy: refused operations leave the stack untouched
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else if (push_i && !full_o) cnt_q <= cnt_q + 1'b1;
    else if (pop_i && !empty_o) cnt_q <= cnt_q - 1'b1;
  // entry storage; contents above the count are don't-care so no reset is needed
  always_ff @(posedge clk_i)
    if (push_i && !full_o) mem_q[IW'(cnt_q)] <= '{prio: prio_i, sp: sp_i};
endmodule

// File: rtl/mpu_stack_guard.sv
// mpu_stack_guard: checks LSU accesses against the task stack frame and per-task region maps
module mpu_stack_guard
  import mpu_stack_guard_pkg::*;
#(
  parameter int                   AddrWidth  = 16,
  parameter int                   Maps       = 9,
  parameter int                   Rows       = 4,
  parameter int                   PrioLevels = 8,
  parameter logic [11:0]          CsrBase    = 12'h400,
  parameter logic [AddrWidth-1:0] StackTop   = '1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [AddrWidth-1:0]          addr,
  input  logic [AddrWidth-1:0]          sp,
  input  logic [6:0]                    op,
  input  logic [$clog2(PrioLevels)-1:0] interrupt_prio,
  input  logic [$clog2(Maps)-1:0]       id,
  input  logic                          csr_enable,
  input  logic [11:0]                   csr_addr,
  input  logic [4:0]                    rs1_zimm,
  input  logic [31:0]                   rs1_data,
  input  logic [2:0]                    csr_op,
  input  logic [11:0]                   vcsr_addr,
  input  logic [11:0]                   vcsr_width,
  input  logic [11:0]                   vcsr_offset,
  input  logic                          fault_clear,
  output logic                          mem_fault_out,
  output logic                          fault_valid,
  output logic [AddrWidth-1:0]          fault_addr,
  output logic [1:0]                    fault_cause
);
  localparam int PW      = $clog2(PrioLevels);
  localparam int Entries = Maps * Rows;
  localparam int IW      = $clog2(Entries);
  logic [31:0]          regions_q [Entries];
  mpu_region_t          map_q [Rows];
  logic [PW-1:0]        last_prio_q;
  logic                 fault_q, fault_valid_q;
  logic [AddrWidth-1:0] fault_addr_q, fault_addr_d;
  mpu_cause_t           fault_cause_q, fault_cause_d;
  logic [11:0]          win_off, eff_addr, idx;
  logic [IW-1:0]        sel;
  logic [31:0]          csr_src;
  logic                 csr_hit;
  logic [PW-1:0]        top_prio;
  logic [AddrWidth-1:0] top_sp, ep;
  logic                 full, empty, push, pop, ep_err;
  logic                 is_ld, is_st, own, grant, det;
  function automatic logic hit(mpu_region_t rg, logic [AddrWidth-1:0] a, logic st);
    logic [AddrWidth:0] bot, top;
    bot = {1'b0, AddrWidth'({rg.base, 2'b00})};
    top = bot + {1'b0, AddrWidth'(rg.length)};
    return {1'b0, a} >= bot && {1'b0, a} < top && (st ? rg.write_en : rg.read_en);
  endfunction
  assign win_off  = csr_addr - vcsr_addr;
  assign eff_addr = win_off < vcsr_width ? CsrBase + vcsr_offset + win_off : csr_addr;
  assign idx      = eff_addr - CsrBase;
  assign sel      = IW'(idx);
  assign csr_hit  = csr_enable && eff_addr >= CsrBase && idx < 12'(Entries);
  assign csr_src  = csr_op[2] ? {27'b0, rs1_zimm} : rs1_data;
  // region table: one 32-bit CSR per map row
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int e = 0; e < Entries; e++) regions_q[e] <= '0;
    else if (csr_hit) regions_q[sel] <= csr_apply(csr_op, regions_q[sel], csr_src);
  // running task's map, reloaded every cycle so table edits reach it one cycle later
  always_ff @(posedge clk or posedge reset)
    if (reset) map_q <= '{default: '0};
    else for (int r = 0; r < Rows; r++)
      map_q[r] <= int'(id) < Maps ? mpu_region_t'(regions_q[IW'(int'(id) * Rows + r)]) : '0;
  assign pop  = empty ? interrupt_prio < last_prio_q : top_prio > interrupt_prio;
  assign push = !pop && interrupt_prio > last_prio_q;
  assign ep   = empty ? StackTop : top_sp;
  mpu_ep_stack #(.Depth(PrioLevels), .PW(PW), .AW(AddrWidth)) u_ep (
    .clk_i(clk), .rst_i(reset), .push_i(push), .pop_i(pop), .prio_i(interrupt_prio), .sp_i(sp),
    .top_prio_o(top_prio), .top_sp_o(top_sp), .full_o(full), .empty_o(empty), .err_o(ep_err)
  );
  // priority seen last cycle; a change relative to it drives push/pop
  always_ff @(posedge clk or posedge reset)
    if (reset) last_prio_q <= '0;
    else last_prio_q <= interrupt_prio;
  // access check against the old ep and current map; ep-stack errors take precedence
  always_comb begin
    is_ld = op == OP_LOAD;
    is_st = op == OP_STORE;
    own   = addr >= sp && addr < ep;
    grant = 1'b0;
    for (int r = 0; r < Rows; r++) grant |= hit(map_q[r], addr, is_st);
    det           = ep_err || (is_ld || is_st) && !(own || grant);
    fault_cause_d = ep_err ? CAUSE_EP : is_st ? CAUSE_STORE : CAUSE_LOAD;
    fault_addr_d  = ep_err ? sp : addr;
  end
  // fault pulse plus sticky record of the first fault; a new fault beats a same-cycle clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fault_q       <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_cause_q <= CAUSE_NONE;
    end else begin
      fault_q <= det;
      if (det && (!fault_valid_q || fault_clear)) begin
        fault_valid_q <= 1'b1;
        fault_addr_q  <= fault_addr_d;
        fault_cause_q <= fault_cause_d;
      end else if (fault_clear) begin
        fault_valid_q <= 1'b0;
        fault_addr_q  <= '0;
        fault_cause_q <= CAUSE_NONE;
      end
    end
  assign mem_fault_out = fault_q;
  assign fault_valid   = fault_valid_q;
  assign fault_addr    = fault_addr_q;
  assign fault_cause   = fault_cause_q;
endmodule

// File: tb/tb_mpu_stack_guard.sv
// tb_mpu_stack_guard: directed spec scenarios plus random traffic against a behavioural model
module tb_mpu_stack_guard;
  import mpu_stack_guard_pkg::*;
  localparam int PL = 5;  // shallower than the 8 encodable priorities so overflow is reachable
  logic        clk = 0, reset = 1;
  logic [15:0] addr = 0, sp = 0;
  logic [6:0]  op = 7'h13;
  logic [2:0]  prio = 0;
  logic [3:0]  id = 0;
  logic        csr_enable = 0;
  logic [11:0] csr_addr = 0;
  logic [4:0]  rs1_zimm = 0;
  logic [31:0] rs1_data = 0;
  logic [2:0]  csr_op = CSR_RW;
  logic [11:0] vcsr_addr = 0, vcsr_width = 0, vcsr_offset = 0;
  logic        fault_clear = 0;
  logic        mem_fault_out, fault_valid;
  logic [15:0] fault_addr;
  logic [1:0]  fault_cause;
  int          n_tests = 0, n_fail = 0;
  int unsigned tbl [36];
  int unsigned cur [4];
  int          stk_prio [$], stk_sp [$];
  int          lastp;
  bit          m_fo, m_fv;
  int          m_fa, m_fc;

  mpu_stack_guard #(.PrioLevels(PL)) dut (
    .clk(clk), .reset(reset), .addr(addr), .sp(sp), .op(op), .interrupt_prio(prio), .id(id),
    .csr_enable(csr_enable), .csr_addr(csr_addr), .rs1_zimm(rs1_zimm), .rs1_data(rs1_data),
    .csr_op(csr_op), .vcsr_addr(vcsr_addr), .vcsr_width(vcsr_width), .vcsr_offset(vcsr_offset),
    .fault_clear(fault_clear), .mem_fault_out(mem_fault_out), .fault_valid(fault_valid),
    .fault_addr(fault_addr), .fault_cause(fault_cause)
  );
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (tbl[i]) tbl[i] = 0;
    foreach (cur[i]) cur[i] = 0;
    stk_prio.delete();
    stk_sp.delete();
    lastp = 0;
    m_fo = 0; m_fv = 0; m_fa = 0; m_fc = 0;
  endfunction

  function automatic void model_step();
    int n, ep, a, s, p, bot, top;
    bit err, ld, st, grant, own, det;
    int unsigned w, off, eff, src;
    int unsigned nxt [4];
    n = stk_sp.size();
    ep = n > 0 ? stk_sp[n-1] : 'hFFFF;
    a = addr; s = sp; p = prio;
    err = 0;
    if (n > 0 && stk_prio[n-1] > p) begin
      stk_prio.delete(n-1);
      stk_sp.delete(n-1);
    end else if (p > lastp) begin
      if (n == PL) err = 1;
      else begin
        stk_prio.push_back(p);
        stk_sp.push_back(s);
      end
    end else if (p < lastp && n == 0) err = 1;
    lastp = p;
    ld = op == OP_LOAD;
    st = op == OP_STORE;
    own = a >= s && a < ep;
    grant = 0;
    foreach (cur[r]) begin
      w = cur[r];
      bot = int'(w >> 18) * 4;
      top = bot + int'((w >> 2) & 'hFFFF);
      if (a >= bot && a < top && (st ? w[1] : w[0])) grant = 1;
    end
    det = err || ((ld || st) && !own && !grant);
    if (det && (!m_fv || fault_clear)) begin
      m_fv = 1;
      m_fa = err ? s : a;
      m_fc = err ? 3 : st ? 2 : 1;
    end else if (fault_clear) begin
      m_fv = 0; m_fa = 0; m_fc = 0;
    end
    m_fo = det;
    foreach (nxt[r]) nxt[r] = id < 9 ? tbl[id * 4 + r] : 0;
    off = (csr_addr - vcsr_addr) & 'hFFF;
    eff = off < vcsr_width ? ('h400 + vcsr_offset + off) & 'hFFF : csr_addr;
    if (csr_enable && eff >= 'h400 && eff < 'h400 + 36) begin
      src = csr_op[2] ? rs1_zimm : rs1_data;
      case (csr_op[1:0])
        2'b01: tbl[eff - 'h400] = src;
        2'b10: tbl[eff - 'h400] |= src;
        2'b11: tbl[eff - 'h400] &= ~src;
        default: ;
      endcase
    end
    cur = nxt;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("pulse", mem_fault_out, m_fo);
    chk("valid", fault_valid, m_fv);
    chk("faddr", fault_addr, m_fa);
    chk("cause", fault_cause, m_fc);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_pulse", mem_fault_out, 0);
    chk("rst_valid", fault_valid, 0);
    chk("rst_faddr", fault_addr, 0);
    chk("rst_cause", fault_cause, 0);
    reset = 0;
    sp = 16'h8000; op = OP_LOAD; addr = 16'h8010;
    cycle();
    chk("own_ok", mem_fault_out, 0);
    addr = 16'h7FF0;
    cycle();
    chk("below_sp", mem_fault_out, 1);
    chk("below_sp_addr", fault_addr, 16'h7FF0);
    chk("below_sp_cause", fault_cause, 1);
    op = 7'h13; fault_clear = 1; id = 2;
    csr_enable = 1; vcsr_addr = 12'h7C0; vcsr_width = 4; vcsr_offset = 8;
    csr_addr = 12'h7C0; csr_op = CSR_RW; rs1_data = 32'h1000_0401;
    cycle();
    fault_clear = 0; csr_enable = 0; vcsr_width = 0;
    cycle();
    op = OP_LOAD; addr = 16'h10FC;
    cycle();
    chk("region_rd", mem_fault_out, 0);
    op = OP_STORE; addr = 16'h1010;
    cycle();
    chk("region_wr_cause", fault_cause, 2);
    op = OP_LOAD; addr = 16'h1100;
    cycle();
    chk("top_excl", mem_fault_out, 1);
    chk("keep_first", fault_addr, 16'h1010);
    fault_clear = 1;
    cycle();
    chk("clr_set_wins_addr", fault_addr, 16'h1100);
    chk("clr_set_wins_valid", fault_valid, 1);
    op = 7'h13; prio = 3; sp = 16'h9000;
    cycle();
    fault_clear = 0; prio = 5; sp = 16'h8800;
    cycle();
    op = OP_LOAD; addr = 16'h8900;
    cycle();
    chk("ep_inner", mem_fault_out, 1);
    op = 7'h13; prio = 3;
    cycle();
    op = OP_LOAD;
    cycle();
    chk("ep_outer", mem_fault_out, 0);
    op = 7'h13; prio = 0; fault_clear = 1;
    cycle();
    fault_clear = 0;
    for (int k = 1; k <= PL; k++) begin
      prio = 3'(k); sp = 16'(32'hA000 - k * 32'h100);
      cycle();
    end
    prio = 6; sp = 16'h9A00;
    cycle();
    chk("ovf_pulse", mem_fault_out, 1);
    chk("ovf_cause", fault_cause, 3);
    op = OP_LOAD; addr = 16'h9AFF;
    cycle();
    chk("ovf_keep", mem_fault_out, 0);
    addr = 16'h9B00;
    cycle();
    chk("ovf_top", mem_fault_out, 1);
    op = 7'h13; prio = 0; fault_clear = 1;
    cycle();
    fault_clear = 0;
    repeat (5) cycle();
    chk("ret_no_err", fault_valid, 0);
    op = OP_LOAD; sp = 0; addr = 16'hFFFE;
    cycle();
    chk("ep_empty", mem_fault_out, 0);
    op = 7'h13; prio = 2; sp = 16'hC000;
    cycle();
    op = OP_LOAD; addr = 0;
    cycle();
    chk("pre_rst_valid", fault_valid, 1);
    #3 reset = 1;
    #1;
    chk("mid_rst_pulse", mem_fault_out, 0);
    chk("mid_rst_valid", fault_valid, 0);
    chk("mid_rst_faddr", fault_addr, 0);
    chk("mid_rst_cause", fault_cause, 0);
    model_reset();
    prio = 0; id = 0; sp = 0; addr = 16'hFFFE;
    #1 reset = 0;
    cycle();
    chk("rst_ep_in", mem_fault_out, 0);
    addr = 16'hFFFF;
    cycle();
    chk("rst_ep_excl", mem_fault_out, 1);
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) prio = 3'($urandom_range(0, 7));
      sp = 16'($urandom);
      addr = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'(sp + 16'($urandom_range(0, 'h400)) - 16'h100);
      case ($urandom_range(0, 2))
        0: op = OP_LOAD;
        1: op = OP_STORE;
        default: op = 7'h13;
      endcase
      if ($urandom_range(0, 15) == 0) id = 4'($urandom_range(0, 9));
      csr_enable = $urandom_range(0, 2) == 0;
      csr_op = 3'($urandom_range(1, 3)) | ($urandom_range(0, 7) == 0 ? 3'b100 : 3'b000);
      rs1_data = $urandom;
      rs1_zimm = 5'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        vcsr_addr = 12'h7C0;
        vcsr_width = 12'($urandom_range(1, 8));
        vcsr_offset = 12'($urandom_range(0, 40));
        csr_addr = 12'(12'h7C0 + $urandom_range(0, 9));
      end else begin
        vcsr_width = 0;
        csr_addr = 12'(12'h3FE + $urandom_range(0, 40));
      end
      fault_clear = $urandom_range(0, 7) == 0;
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
